max_pooling_2d: RTL and testbench
=================================

Name: max_pooling_2d

Overview:
Parametrised 2x2, stride-2 pooling engine for a raster pixel stream, one pixel per accepted beat. It tracks row and column position internally, so no external row flag is needed. It buffers pair results of even rows in a half-row line buffer and emits one pooled value per window. Max or average mode is selectable per frame, and signed data is supported. Sits between a conv/activation stage and the next layer.

Parameters:
DATA_W, 6, pixel and result width in bits
ROW_LEN, 16, input pixels per row; even, >=2
ROWS, 16, input rows per frame; even, >=2
SIGNED, 0, 1 = two's-complement compare and average; 0 = unsigned

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, synchronous, active-high
fire  input  1  data_in valid this cycle; pixel accepted when high
sof  input  1  start of frame; qualified by fire; forces the accepted pixel to row 0, column 0
mode  input  1  0 = max, 1 = average; latched at the first pixel of each frame
data_in  input  DATA_W  pixel
data_out  output  DATA_W  pooled result; holds last value between strobes
done  output  1  one-cycle strobe, data_out valid
frame_done  output  1  one-cycle strobe coincident with the last done of a frame

Behaviour:
- Reset: one clock, synchronous, active-high (rst). On reset, data_out=0, done=0, frame_done=0, col=0, row=0, latched mode=0, and line buffer cleared. rst has priority over fire.
- Counters: col 0..ROW_LEN-1 and row 0..ROWS-1 advance only on accepted pixels. col wraps to 0 and row increments; after the last pixel of the frame, row wraps to 0.
- fire low: all state holds, and done=0. Gaps of any length between pixels are legal.
- sof with fire: col and row are treated as 0 for this pixel. Any partial window is discarded and produces no output.
- Mode latch: mode is captured when a pixel is accepted at row 0, col 0. A mode change mid-frame is ignored.
- Pair register: on an even col, the pixel is held. On an odd col, a pair result P is formed from the held pixel and data_in. In max mode, P = max of the two. In average mode, P = their sum, DATA_W+1 bits, sign-extended when SIGNED=1.
- Even row: P is written to line buffer entry col/2. The buffer has ROW_LEN/2 entries of DATA_W+1 bits.
- Odd row: P is combined with buffer entry col/2.
  - Max mode: result = max of the two.
  - Average mode: result = sum of all four pixels, DATA_W+2 bits, shifted right by 2. The shift is logical for unsigned data and arithmetic (floor) when SIGNED=1. Result truncated to DATA_W bits.
- Latency: data_out is registered. done is high in the cycle after the odd-row, odd-col pixel is accepted.
- Throughput: one output per 4 input pixels; ROW_LEN*ROWS/4 outputs per frame.
- frame_done: asserted together with done for the window at row ROWS-1, col ROW_LEN-1.
- Back-to-back frames: a new frame may start in the cycle after the last pixel, with or without sof.
- Compare ties: either operand may be selected; the value is identical.
- Implementation: no combinational path from inputs to outputs. Single clock domain, no handshake backpressure; the source must obey the fire protocol.

Test Plan:
1. Max mode, defaults. Row 0 = 1..16; row 1 = 21,22,23,24,25,26,27,28,9,10,1,2,3,4,5,6. Required: 8 done strobes with data_out = 22,24,26,28,10,12,14,16, each strobe one cycle after the 2nd, 4th, … pixel of row 1.
2. Same stimulus with mode=1 at sof. Required: data_out = 11,13,15,17,9,6,8,10.
3. Same stimulus with fire deasserted for 3 cycles after every pixel. Required: identical data_out sequence; done never high during gaps; each done exactly one cycle after its closing pixel.
4. ROWS=4, max mode, continuous pixels 0..63 (value = row*16+col). Required: 16 outputs = 17,19,…,31,49,51,…,63. frame_done pulses only with the final value 63, then the next frame restarts cleanly.
5. rst asserted for 1 cycle mid-row 1, followed by a fresh frame from test 1. Required: data_out=0 and done=0 immediately after reset, no stale output from the aborted frame, then the exact test 1 sequence.
6. SIGNED=1, one window with pixels 6'h3F, 6'h20 (row 0) and 6'h3B, 6'h3E (row 1). Required: max mode data_out = 6'h3F (−1); average mode with pixels −1,−2,−3,−4 gives data_out = 6'h3D (−3, floored).

Source files
------------

// File: rtl/max_pooling_2d.sv
// 2x2, stride-2 max/average pooling over a raster pixel stream.
// Row pair results are parked in a half-row line buffer until the odd row closes each window.
module max_pooling_2d #(
    parameter int DATA_W  = 6,
    parameter int ROW_LEN = 16,
    parameter int ROWS    = 16,
    parameter int SIGNED  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fire,
    input  logic              sof,
    input  logic              mode,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              done,
    output logic              frame_done
);

    localparam int COL_W = $clog2(ROW_LEN);
    localparam int ROW_W = $clog2(ROWS);
    localparam int BUF_N = ROW_LEN / 2;
    localparam int IDX_W = (BUF_N > 1) ? $clog2(BUF_N) : 1;
    localparam int PW    = DATA_W + 1;
    localparam int EW    = DATA_W + 2;

    function automatic logic [EW-1:0] ext_px(input logic [DATA_W-1:0] x);
        return {{2{(SIGNED != 0) & x[DATA_W-1]}}, x};
    endfunction

    function automatic logic [EW-1:0] ext_pair(input logic [PW-1:0] p);
        return {(SIGNED != 0) & p[PW-1], p};
    endfunction

    // Flipping the MSB turns a two's-complement compare into an unsigned one.
    function automatic logic [EW-1:0] max_ext(input logic [EW-1:0] a, input logic [EW-1:0] b);
        logic [EW-1:0] bias;
        bias         = '0;
        bias[EW-1]   = (SIGNED != 0);
        return ((a ^ bias) > (b ^ bias)) ? a : b;
    endfunction

    logic [COL_W-1:0]  col_q, col_d, col_eff;
    logic [ROW_W-1:0]  row_q, row_d, row_eff;
    logic              mode_q, mode_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [PW-1:0]     lbuf_q [BUF_N];
    logic [PW-1:0]     lbuf_d [BUF_N];
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              done_q, done_d;
    logic              frame_done_q, frame_done_d;

    logic [IDX_W-1:0]  idx;
    logic [EW-1:0]     px_a, px_b, pair_sum, pair_e, buf_e, quad_sum;
    logic [PW-1:0]     pair;
    logic [DATA_W-1:0] result;
    logic              last_col, last_row;

    // NOTE: every variable gets a default first so no path through this block infers a latch.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        mode_d       = mode_q;
        hold_d       = hold_q;
        lbuf_d       = lbuf_q;
        data_out_d   = data_out_q;
        done_d       = 1'b0;
        frame_done_d = 1'b0;

        col_eff  = (fire && sof) ? '0 : col_q;
        row_eff  = (fire && sof) ? '0 : row_q;
        idx      = IDX_W'(col_eff >> 1);
        last_col = (col_eff == COL_W'(ROW_LEN - 1));
        last_row = (row_eff == ROW_W'(ROWS - 1));

        px_a     = ext_px(hold_q);
        px_b     = ext_px(data_in);
        pair_sum = px_a + px_b;
        pair     = mode_q ? PW'(pair_sum) : PW'(max_ext(px_a, px_b));

        pair_e   = ext_pair(pair);
        buf_e    = ext_pair(lbuf_q[idx]);
        quad_sum = buf_e + pair_e;
        // Truncating the shifted sum makes logical and arithmetic shifts identical here.
        result   = mode_q ? DATA_W'(quad_sum >> 2) : DATA_W'(max_ext(buf_e, pair_e));

        if (fire) begin
            if (col_eff == '0 && row_eff == '0) begin
                mode_d = mode;
            end

            if (!col_eff[0]) begin
                hold_d = data_in;
            end else if (!row_eff[0]) begin
                lbuf_d[idx] = pair;
            end else begin
                done_d       = 1'b1;
                data_out_d   = result;
                frame_done_d = last_row && last_col;
            end

            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_eff + 1'b1;
            end else begin
                col_d = col_eff + 1'b1;
                row_d = row_eff;
            end
        end
    end

    // NOTE: the line buffer is small and must read as zero after reset, so it is reset like any other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            mode_q       <= 1'b0;
            hold_q       <= '0;
            lbuf_q       <= '{default: '0};
            data_out_q   <= '0;
            done_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the pre-edge values.
            col_q        <= col_d;
            row_q        <= row_d;
            mode_q       <= mode_d;
            hold_q       <= hold_d;
            lbuf_q       <= lbuf_d;
            data_out_q   <= data_out_d;
            done_q       <= done_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign data_out   = data_out_q;
    assign done       = done_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_max_pooling_2d.sv
// Directed-plus-random bench for max_pooling_2d; expectations come from whole-window arithmetic
// over the frame image the bench itself sends.
module tb_max_pooling_2d;

    localparam int DW = 6;
    localparam int RL = 16;

    logic          clk = 1'b0;
    logic          rst, fire, sof, mode;
    logic [DW-1:0] data_in;

    logic [DW-1:0] dout0, dout4, douts;
    logic          done0, done4, dones;
    logic          fd0, fd4, fds;

    always #5 clk = ~clk;

    max_pooling_2d #(.DATA_W(DW), .ROW_LEN(RL), .ROWS(16), .SIGNED(0)) u_dut (
        .clk(clk), .rst(rst), .fire(fire), .sof(sof), .mode(mode), .data_in(data_in),
        .data_out(dout0), .done(done0), .frame_done(fd0));

    max_pooling_2d #(.DATA_W(DW), .ROW_LEN(RL), .ROWS(4), .SIGNED(0)) u_dut_rows4 (
        .clk(clk), .rst(rst), .fire(fire), .sof(sof), .mode(mode), .data_in(data_in),
        .data_out(dout4), .done(done4), .frame_done(fd4));

    max_pooling_2d #(.DATA_W(DW), .ROW_LEN(RL), .ROWS(16), .SIGNED(1)) u_dut_signed (
        .clk(clk), .rst(rst), .fire(fire), .sof(sof), .mode(mode), .data_in(data_in),
        .data_out(douts), .done(dones), .frame_done(fds));

    int            n_cmp = 0;
    int            n_err = 0;
    int            sel   = 0;
    logic [DW-1:0] pix [16][16];

    logic [DW-1:0] obs_data;
    logic          obs_done, obs_fd;

    always_comb begin
        case (sel)
            1:       begin obs_data = dout4; obs_done = done4; obs_fd = fd4; end
            2:       begin obs_data = douts; obs_done = dones; obs_fd = fds; end
            default: begin obs_data = dout0; obs_done = done0; obs_fd = fd0; end
        endcase
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge pass, then check what the DUT registered.
    task automatic step(input logic f, input logic s, input logic m, input logic [DW-1:0] d,
                        input bit ev, input logic [DW-1:0] ev_val, input bit efd, input string tag);
        fire    = f;
        sof     = s;
        mode    = m;
        data_in = d;
        @(posedge clk);
        #1;
        chk({tag, " done"}, 8'(obs_done), 8'(ev));
        chk({tag, " frame_done"}, 8'(obs_fd), 8'(efd));
        if (ev) chk({tag, " data_out"}, 8'(obs_data), 8'(ev_val));
    endtask

    function automatic int sval(input logic [DW-1:0] x, input bit sgn);
        return (sgn && x[DW-1]) ? int'(x) - 64 : int'(x);
    endfunction

    // Pooled value of the 2x2 window whose bottom-right pixel is (r, c).
    function automatic logic [DW-1:0] win_exp(input int r, input int c, input bit m, input bit sgn);
        int v [4];
        int res;
        int sum;
        v[0] = sval(pix[r-1][c-1], sgn);
        v[1] = sval(pix[r-1][c], sgn);
        v[2] = sval(pix[r][c-1], sgn);
        v[3] = sval(pix[r][c], sgn);
        if (!m) begin
            res = v[0];
            for (int i = 1; i < 4; i++) if (v[i] > res) res = v[i];
        end else begin
            sum = v[0] + v[1] + v[2] + v[3];
            res = sum / 4;
            if (sum < 0 && (sum % 4) != 0) res = res - 1;
        end
        return res[DW-1:0];
    endfunction

    // Send the first npix pixels of pix[][] in raster order, with gaps of gmin..gmax idle cycles.
    task automatic send(input int npix, input int frows, input bit m, input bit use_sof,
                        input int gmin, input int gmax, input bit sgn, input string tag);
        int            r, c, g;
        bit            ev, efd;
        logic [DW-1:0] ev_val;
        for (int k = 0; k < npix; k++) begin
            r      = k / RL;
            c      = k % RL;
            ev     = (r % 2 == 1) && (c % 2 == 1);
            ev_val = ev ? win_exp(r, c, m, sgn) : '0;
            efd    = ev && (r == frows - 1) && (c == RL - 1);
            step(1'b1, use_sof && (k == 0), (k == 0) ? m : 1'($urandom), pix[r][c],
                 ev, ev_val, efd, tag);
            g = int'($urandom_range(gmax, gmin));
            for (int j = 0; j < g; j++) begin
                step(1'b0, 1'($urandom), 1'($urandom), DW'($urandom), 1'b0, '0, 1'b0, {tag, " gap"});
            end
        end
    endtask

    task automatic fill_test1();
        int row1 [16] = '{21, 22, 23, 24, 25, 26, 27, 28, 9, 10, 1, 2, 3, 4, 5, 6};
        for (int c = 0; c < RL; c++) begin
            pix[0][c] = DW'(c + 1);
            pix[1][c] = DW'(row1[c]);
        end
    endtask

    task automatic fill_random();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < RL; c++)
                pix[r][c] = DW'($urandom);
    endtask

    initial begin
        bit m;

        rst     = 1'b1;
        fire    = 1'b0;
        sof     = 1'b0;
        mode    = 1'b0;
        data_in = '0;
        sel     = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset data_out", 8'(dout0), 8'h00);
        chk("reset done", 8'(done0), 8'h00);
        chk("reset frame_done", 8'(fd0), 8'h00);
        chk("reset signed data_out", 8'(douts), 8'h00);

        // Max and average over the two directed rows, then the same with 3-cycle gaps.
        fill_test1();
        send(32, 16, 1'b0, 1'b0, 0, 0, 1'b0, "t1 max");
        send(32, 16, 1'b1, 1'b1, 0, 0, 1'b0, "t2 avg");
        send(32, 16, 1'b0, 1'b1, 3, 3, 1'b0, "t3 gaps max");
        send(32, 16, 1'b1, 1'b1, 3, 3, 1'b0, "t3 gaps avg");

        // Four-row frame with a ramp image, then an immediate random frame without sof.
        sel = 1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < RL; c++)
                pix[r][c] = DW'(r * 16 + c);
        send(64, 4, 1'b0, 1'b1, 0, 0, 1'b0, "t4 ramp");
        fill_random();
        m = 1'($urandom);
        send(64, 4, m, 1'b0, 0, 1, 1'b0, "t4 back2back");

        // Reset mid row 1 discards the partial frame; the next frame needs no sof.
        sel = 0;
        fill_test1();
        send(21, 16, 1'b0, 1'b1, 0, 0, 1'b0, "t5 pre");
        rst     = 1'b1;
        fire    = 1'b1;
        sof     = 1'b0;
        data_in = 6'h3F;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        fire = 1'b0;
        chk("t5 reset data_out", 8'(dout0), 8'h00);
        chk("t5 reset done", 8'(done0), 8'h00);
        send(32, 16, 1'b0, 1'b0, 0, 0, 1'b0, "t5 fresh");

        // Signed windows, including the -1 maximum and the floored -3 average.
        sel = 2;
        fill_random();
        pix[0][0] = 6'h3F; pix[0][1] = 6'h20; pix[1][0] = 6'h3B; pix[1][1] = 6'h3E;
        send(32, 16, 1'b0, 1'b1, 0, 0, 1'b1, "t6 signed max");
        fill_random();
        pix[0][0] = 6'h3F; pix[0][1] = 6'h3E; pix[1][0] = 6'h3D; pix[1][1] = 6'h3C;
        send(32, 16, 1'b1, 1'b1, 0, 0, 1'b1, "t6 signed avg");

        // Full random frames: back-to-back unsigned with gaps, then a signed frame.
        sel = 0;
        fill_random();
        m = 1'($urandom);
        send(256, 16, m, 1'b1, 0, 2, 1'b0, "rnd frame0");
        fill_random();
        m = 1'($urandom);
        send(256, 16, m, 1'b0, 0, 1, 1'b0, "rnd frame1");
        sel = 2;
        fill_random();
        m = 1'($urandom);
        send(256, 16, m, 1'b1, 0, 1, 1'b1, "rnd signed");

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, "idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
